// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous input in clk cycles and
// hands each completed measurement to a valid/ready consumer.
module clk_period_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_meas_in,
  input  logic             i_meas_ready,
  output logic             o_meas_valid,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_high_time,
  output logic             o_overrun,
  output logic             o_timeout,
  output logic             o_busy
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_hcnt;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_hcnt_next;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high_time;
  logic             r_meas_valid;
  logic             r_overrun;
  logic             r_timeout;
  logic             r_busy;

  logic w_rise;
  logic w_complete;
  logic w_expire;
  logic w_transfer;

  // s1/s2 form the synchroniser; s3 only exists to find the rising edge of s2.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_meas_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise     = r_s2 & ~r_s3;
  assign w_complete = (r_state == ST_MEASURE) & w_rise;
  assign w_expire   = (r_state == ST_MEASURE) & ~w_rise & (r_cnt == TIMEOUT_W);
  assign w_transfer = r_meas_valid & i_meas_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_hcnt  <= w_hcnt_next;
    end
  end

  // Counters restart at 1 on a rise because the rise cycle itself is high.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_hcnt_next  = r_hcnt;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_next = ST_MEASURE;
          w_cnt_next   = ONE_W;
          w_hcnt_next  = ONE_W;
        end
      end
      ST_MEASURE: begin
        if (w_rise) begin
          w_cnt_next  = ONE_W;
          w_hcnt_next = ONE_W;
        end else if (r_cnt == TIMEOUT_W) begin
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + ONE_W;
          if (r_s2) begin
            w_hcnt_next = r_hcnt + ONE_W;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_period     <= '0;
      r_high_time  <= '0;
      r_meas_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_busy <= (w_state_next == ST_MEASURE);
      if (w_complete) begin
        r_period     <= r_cnt;
        r_high_time  <= r_hcnt;
        r_meas_valid <= 1'b1;
      end else if (w_transfer) begin
        r_meas_valid <= 1'b0;
      end
      // A completion landing on an unconsumed result loses the old one.
      if (w_complete && r_meas_valid && !i_meas_ready) begin
        r_overrun <= 1'b1;
      end else if (w_transfer) begin
        r_overrun <= 1'b0;
      end
      if (w_complete) begin
        r_timeout <= 1'b0;
      end else if (w_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_meas_valid = r_meas_valid;
  assign o_period     = r_period;
  assign o_high_time  = r_high_time;
  assign o_overrun    = r_overrun;
  assign o_timeout    = r_timeout;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: table of square waves scored through a queue,
// plus hand-built reset, timeout and backpressure sequences.
module tb_clk_period_meter;
  localparam int WIDTH = 16;
  localparam int TMO   = 50;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             meas_in = 1'b0;
  logic             meas_ready = 1'b0;
  logic             meas_valid;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             overrun;
  logic             timeout;
  logic             busy;

  always #5 clk = ~clk;

  clk_period_meter #(.WIDTH(WIDTH), .TIMEOUT(TMO)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_meas_in    (meas_in),
    .i_meas_ready (meas_ready),
    .o_meas_valid (meas_valid),
    .o_period     (period),
    .o_high_time  (high_time),
    .o_overrun    (overrun),
    .o_timeout    (timeout),
    .o_busy       (busy)
  );

  typedef struct {
    int p;
    int h;
    int n;
    int exp_p;
    int exp_h;
  } vec_t;

  typedef struct {
    int p;
    int h;
  } meas_t;

  vec_t  tbl[5];
  meas_t sb_q[$];
  meas_t prev;
  bit    have_prev = 1'b0;
  bit    mon_en = 1'b0;
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"},   meas_valid, 0);
    check({tag, "_period"},  period,     0);
    check({tag, "_high"},    high_time,  0);
    check({tag, "_overrun"}, overrun,    0);
    check({tag, "_timeout"}, timeout,    0);
    check({tag, "_busy"},    busy,       0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A rise completes the previous full cycle, so its result is expected now.
  task automatic start_rise();
    if (mon_en && have_prev) sb_q.push_back(prev);
    meas_in = 1'b1;
  endtask

  task automatic drive_cycle(input int p, input int h, input int ep, input int eh);
    start_rise();
    repeat (h) tick();
    meas_in = 1'b0;
    repeat (p - h) tick();
    prev = '{ep, eh};
    have_prev = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n && meas_valid && meas_ready) begin
      check("sb_nonempty", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        meas_t e;
        e = sb_q.pop_front();
        $display("xfer period=%0d high_time=%0d (exp %0d/%0d)", period, high_time, e.p, e.h);
        check("period",    period,    e.p);
        check("high_time", high_time, e.h);
        check("overrun",   overrun,   0);
        check("timeout",   timeout,   0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{10, 5, 4, 10, 5};
    tbl[1] = '{7, 2, 4, 7, 2};
    tbl[2] = '{16, 12, 3, 16, 12};
    tbl[3] = '{3, 1, 4, 3, 1};
    tbl[4] = '{2, 1, 4, 2, 1};

    // Reset held while the input toggles.
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      meas_in = ~meas_in;
      tick();
    end
    check_reset("rst");
    meas_in = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("busy_after_release", busy, 0);

    // Lead-in cycle (10/5) with busy checked around the first rise detect.
    meas_ready = 1'b1;
    mon_en = 1'b1;
    have_prev = 1'b0;
    start_rise();
    repeat (2) tick();
    check("busy_before_rise", busy, 0);
    tick();
    check("busy_after_rise", busy, 1);
    repeat (2) tick();
    meas_in = 1'b0;
    repeat (5) tick();
    prev = '{10, 5};
    have_prev = 1'b1;

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        drive_cycle(tbl[i].p, tbl[i].h, tbl[i].exp_p, tbl[i].exp_h);
      end
    end

    // Timeout: one more 10/5 cycle, a final rise, then input held low.
    drive_cycle(10, 5, 10, 5);
    start_rise();
    repeat (5) tick();
    meas_in = 1'b0;
    repeat (47) tick();
    check("sb_drained_before_timeout", sb_q.size(), 0);
    check("timeout_not_yet", timeout, 0);
    check("busy_not_yet", busy, 1);
    tick();
    check("timeout_set", timeout, 1);
    check("busy_cleared", busy, 0);
    check("period_held", period, 10);
    check("high_held", high_time, 5);
    have_prev = 1'b0;

    // Two rises after timeout produce a fresh measurement and clear timeout.
    drive_cycle(10, 5, 10, 5);
    drive_cycle(10, 5, 10, 5);
    check("timeout_cleared", timeout, 0);
    check("sb_drained_after_timeout", sb_q.size(), 0);
    repeat (60) tick();
    check("timeout_again", timeout, 1);

    // Backpressure: three completions with no consumer.
    mon_en = 1'b0;
    meas_ready = 1'b0;
    have_prev = 1'b0;
    for (int k = 0; k < 4; k++) drive_cycle(10, 5, 10, 5);
    check("bp_valid_held", meas_valid, 1);
    check("bp_period", period, 10);
    check("bp_high", high_time, 5);
    check("bp_overrun", overrun, 1);
    check("bp_timeout_cleared", timeout, 0);
    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;
    check("bp_valid_after_xfer", meas_valid, 0);
    check("bp_overrun_after_xfer", overrun, 0);
    repeat (60) tick();

    // Mid-run reset at cnt == 6, then a clean restart needing two rises.
    sb_q.delete();
    mon_en = 1'b1;
    meas_ready = 1'b1;
    have_prev = 1'b0;
    drive_cycle(10, 5, 10, 5);
    drive_cycle(10, 5, 10, 5);
    start_rise();
    repeat (5) tick();
    meas_in = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) tick();
    rst_n = 1'b1;
    have_prev = 1'b0;
    repeat (2) tick();
    check("midrst_busy_idle", busy, 0);
    for (int k = 0; k < 3; k++) drive_cycle(10, 5, 10, 5);
    repeat (5) tick();
    check("sb_drained_end", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Measures an incoming slow clock/strobe (e.g. output of the team's clock divider) in units of the system clock: period (rise-to-rise) and high time.
- Synchronises the asynchronous input, detects edges, counts, and presents each completed measurement on a valid/ready interface.
- Sits on the consuming side of divided-clock generation; used for self-check and frequency monitoring.

Parameters:
- WIDTH, 32, width of period/high_time counters and outputs.
- TIMEOUT, 1000000, clk cycles without a rising edge before a measurement is abandoned; must satisfy 2 <= TIMEOUT <= 2^WIDTH-1.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- meas_in  input  1  signal under measurement, asynchronous to clk.
- meas_ready  input  1  consumer accepts the current measurement.
- meas_valid  output  1  measurement available; held until accepted.
- period  output  WIDTH  clk cycles between consecutive detected rising edges.
- high_time  output  WIDTH  clk cycles meas_in was sampled high within that period.
- overrun  output  1  sticky: unaccepted measurement was overwritten.
- timeout  output  1  sticky: TIMEOUT elapsed with no rising edge.
- busy  output  1  high in MEASURE state.

Behaviour:
- Reset (rst_n=0, async):
  - sync regs s1, s2, s3 = 0; state = IDLE; cnt = 0; hcnt = 0.
  - period = 0, high_time = 0, meas_valid = 0, overrun = 0, timeout = 0, busy = 0.
- Synchroniser: s1 <= meas_in, s2 <= s1, s3 <= s2. Rise detect rise = s2 & ~s3, i.e. 3 clk edges after meas_in goes high.
- States:
  - IDLE: cnt, hcnt held. On rise: cnt <= 1, hcnt <= 1, go MEASURE.
  - MEASURE, no rise, cnt < TIMEOUT:
    - cnt <= cnt+1.
    - hcnt <= hcnt+1 when s2=1, else hold.
  - MEASURE with rise (measurement complete):
    - period <= cnt; high_time <= hcnt.
    - cnt <= 1, hcnt <= 1; stay MEASURE; meas_valid <= 1; timeout <= 0.
  - MEASURE with no rise and cnt == TIMEOUT: timeout <= 1, go IDLE; period and high_time unchanged.
- Arithmetic: unsigned. cnt never exceeds TIMEOUT, so hcnt <= cnt and neither counter overflows.
- Handshake:
  - Transfer when meas_valid & meas_ready. meas_valid clears next cycle unless a new completion occurs in the same cycle.
  - Completion with meas_valid=1 and meas_ready=0: period and high_time are overwritten with the new values, meas_valid stays 1, overrun <= 1.
  - Completion and transfer in the same cycle: the old value is consumed and the new one loaded; meas_valid stays 1; no overrun.
  - overrun clears on the next transfer cycle unless an overrun condition also occurs in that cycle (set wins).
  - meas_ready while meas_valid=0 is ignored.
- Constant-high or constant-low input: no rise, so TIMEOUT, then IDLE. Constant high gives no false measurement.
- Glitches shorter than one clk may be missed. Any pulse seen high by s2 for at least 1 cycle counts as a rise.
- busy = (state == MEASURE), registered.
- Reset mid-measurement: everything returns to reset values immediately. The first measurement after reset needs two new rises.

Test Plan:
- Reset: rst_n=0 with meas_in toggling -> all outputs 0, busy=0. Release -> busy=1 only after the first rise is detected.
- Square wave, period 10 clk, high 5 clk, meas_ready=1 -> meas_valid pulses 1 cycle every 10 cycles with period=10, high_time=5, starting at the second detected rise. overrun=0, timeout=0.
- Duty change: period 7, high 2 -> period=7, high_time=2. Then change to period 16, high 12 -> the first full new cycle reports period=16, high_time=12.
- Backpressure: meas_ready=0 for 3 completions (period 10) -> meas_valid stays 1, period=10, overrun=1. Assert meas_ready one cycle with no coincident completion -> transfer, meas_valid=0, overrun=0.
- Timeout: TIMEOUT=50, two rises 10 apart then meas_in held low -> valid with period=10. Exactly 50 cycles after the last rise-detect cycle, timeout=1, busy=0. A new rise pair clears timeout with a valid measurement.
- Mid-run reset: assert rst_n=0 at cnt=6 during a period-10 wave -> immediate reset values. After release, the next meas_valid reports period=10 (no partial value).
